// File: rtl/capture_sequencer_pkg.sv
// capture_sequencer_pkg: state encoding and shared constants for the capture sequencer.
package capture_sequencer_pkg;
  localparam int CNT_W_DEF = 16;
  localparam int SAMPLE_LIMIT_CONTINUOUS = 0;
  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;
endpackage

// File: rtl/capture_sequencer_if.sv
// capture_sequencer_if: command, divider and capture-datapath signals of the capture sequencer.
interface capture_sequencer_if
  import capture_sequencer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic             start;
  logic             abort;
  logic [7:0]       divisor;
  logic [CNT_W-1:0] sample_limit;
  logic             trig_en;
  logic             trig;
  logic             tick;
  logic             div_enable;
  logic [7:0]       div_divisor;
  logic             sample_strobe;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] sample_count;
  modport master (
    output start, abort, divisor, sample_limit, trig_en, trig, tick,
    input  div_enable, div_divisor, sample_strobe, busy, done, sample_count
  );
  modport slave (
    input  start, abort, divisor, sample_limit, trig_en, trig, tick,
    output div_enable, div_divisor, sample_strobe, busy, done, sample_count
  );
endinterface

// File: rtl/capture_sequencer_sample_counter.sv
// sample_counter: remaining-sample down-counter with zero flag plus saturating strobe counter.
module sample_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] limit,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             zero
);
  logic [CNT_W-1:0] remaining;
  // remaining is preloaded one short so zero marks the tick that issues the final strobe
  assign zero = remaining == '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      remaining <= '0;
    end else if (load) begin
      count     <= '0;
      remaining <= limit - CNT_W'(1);
    end else if (inc) begin
      count     <= &count ? count : count + CNT_W'(1);
      remaining <= zero ? remaining : remaining - CNT_W'(1);
    end
  end
endmodule

// File: rtl/capture_sequencer.sv
// capture_sequencer: runs one divided-rate capture, gating the external divider and
// turning its ticks into sample strobes until the limit is reached or an abort arrives.
module capture_sequencer
  import capture_sequencer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  capture_sequencer_if.slave bus
);
  state_t     state, state_nx;
  logic       trig_en_q, cont_q, accept, fire, rem_zero, strobe;
  logic [7:0] div_q;
  assign accept = state == IDLE && bus.start;
  assign fire   = state == RUN && bus.tick && !bus.abort;
  always_comb begin
    state_nx = state;
    if (state != IDLE && bus.abort) state_nx = IDLE;
    else
      case (state)
        IDLE:    state_nx = bus.start ? ARM : IDLE;
        ARM:     state_nx = (!trig_en_q || bus.trig) ? RUN : ARM;
        RUN:     state_nx = (fire && !cont_q && rem_zero) ? DONE : RUN;
        default: state_nx = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      div_q     <= '0;
      trig_en_q <= 1'b0;
      cont_q    <= 1'b0;
      strobe    <= 1'b0;
    end else begin
      state  <= state_nx;
      strobe <= fire;
      if (accept) begin
        div_q     <= bus.divisor;
        trig_en_q <= bus.trig_en;
        cont_q    <= bus.sample_limit == CNT_W'(SAMPLE_LIMIT_CONTINUOUS);
      end
    end
  end
  sample_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .limit (bus.sample_limit),
    .inc   (fire),
    .count (bus.sample_count),
    .zero  (rem_zero)
  );
  assign bus.div_enable    = state == RUN;
  assign bus.div_divisor   = div_q;
  assign bus.sample_strobe = strobe;
  assign bus.busy          = state != IDLE;
  assign bus.done          = state == DONE;
endmodule

// File: tb/tb_capture_sequencer.sv
// tb_capture_sequencer: directed runs against a behavioural model with an attached divider.
module tb_capture_sequencer;
  localparam int W = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  capture_sequencer_if #(.CNT_W(W)) bus ();
  capture_sequencer #(.CNT_W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  // divider: first tick divisor+1 cycles after enable rises, then every divisor+1
  logic [7:0] dcnt;
  always @(posedge clk)
    if (!rst_n || !bus.div_enable) begin dcnt <= 0; bus.tick <= 1'b0; end
    else if (dcnt == bus.div_divisor) begin dcnt <= 0; bus.tick <= 1'b1; end
    else begin dcnt <= dcnt + 8'd1; bus.tick <= 1'b0; end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask
  logic m_busy, m_en, m_done, m_strobe, m_cont, m_trig;
  int m_count, m_left;
  logic [7:0] m_div;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_busy = 0; m_en = 0; m_done = 0; m_strobe = 0; m_cont = 0; m_trig = 0;
      m_count = 0; m_left = 0; m_div = 0;
    end else begin
      m_strobe = m_en && bus.tick && !bus.abort;
      if (m_busy && bus.abort) begin m_busy = 0; m_en = 0; m_done = 0; end
      else if (!m_busy) begin
        if (bus.start) begin
          m_busy = 1; m_div = bus.divisor; m_left = int'(bus.sample_limit);
          m_cont = bus.sample_limit == 0; m_trig = bus.trig_en; m_count = 0;
        end
      end else if (m_done) begin m_done = 0; m_busy = 0; end
      else if (!m_en) m_en = !m_trig || bus.trig;
      else if (m_strobe) begin
        m_count = m_count == 65535 ? m_count : m_count + 1;
        if (!m_cont) begin
          m_left--;
          if (m_left == 0) begin m_en = 0; m_done = 1; end
        end
      end
    end
  int n_st, n_done, n_en, first_en, first_busy, idle_cyc, done_cyc, last_en;
  int st_cyc[32];
  always @(negedge clk)
    if (rst_n) begin
      chk("busy", bus.busy, m_busy);
      chk("div_enable", bus.div_enable, m_en);
      chk("done", bus.done, m_done);
      chk("sample_strobe", bus.sample_strobe, m_strobe);
      chk("sample_count", bus.sample_count, m_count);
      chk("div_divisor", bus.div_divisor, m_div);
      if (bus.sample_strobe) begin if (n_st < 32) st_cyc[n_st] = cyc; n_st++; end
      if (bus.done) begin n_done++; done_cyc = cyc; end
      if (bus.div_enable) begin n_en++; last_en = cyc; if (first_en < 0) first_en = cyc; end
      if (bus.busy && first_busy < 0) first_busy = cyc;
      if (!bus.busy && first_busy >= 0 && idle_cyc < 0) idle_cyc = cyc;
    end
  task automatic clr();
    n_st = 0; n_done = 0; n_en = 0; first_en = -1; first_busy = -1;
    idle_cyc = -1; done_cyc = -1; last_en = -1;
  endtask
  task automatic start_run(input int div, input int lim, input logic ten, output int s);
    @(negedge clk); #1;
    clr();
    bus.divisor = 8'(div); bus.sample_limit = W'(lim); bus.trig_en = ten; bus.start = 1'b1;
    s = cyc + 1;
    @(negedge clk); #1;
    bus.start = 1'b0;
  endtask
  task automatic wait_idle(input int max);
    int k = 0;
    while (bus.busy && k < max) begin @(negedge clk); #1; k++; end
    if (bus.busy) chk("idle_timeout", 1, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  int s, t, a;
  logic tk;
  initial begin
    bus.start = 0; bus.abort = 0; bus.divisor = 0; bus.sample_limit = 0;
    bus.trig_en = 0; bus.trig = 0;
    clr();
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0); chk("rst_en", bus.div_enable, 0);
    chk("rst_count", bus.sample_count, 0); chk("rst_div", bus.div_divisor, 0);
    chk("rst_done", bus.done, 0); chk("rst_strobe", bus.sample_strobe, 0);
    #1 rst_n = 1'b1;
    // limited run with divisor 3: strobes every 4 cycles
    start_run(3, 4, 0, s);
    wait_idle(100);
    repeat (2) @(negedge clk); #1;
    chk("t1_first_busy", first_busy, s); chk("t1_first_en", first_en, s + 1);
    chk("t1_strobes", n_st, 4); chk("t1_first_strobe", st_cyc[0], s + 6);
    chk("t1_gap01", st_cyc[1] - st_cyc[0], 4); chk("t1_gap23", st_cyc[3] - st_cyc[2], 4);
    chk("t1_done_cyc", done_cyc, s + 18); chk("t1_done_with_strobe", done_cyc, st_cyc[3]);
    chk("t1_done_n", n_done, 1); chk("t1_count", bus.sample_count, 4);
    chk("t1_idle_cyc", idle_cyc, s + 19); chk("t1_en_cycles", n_en, 17);
    // single sample, divisor 0
    start_run(0, 1, 0, s);
    wait_idle(50);
    repeat (2) @(negedge clk); #1;
    chk("t2_strobes", n_st, 1); chk("t2_en_cycles", n_en, 2);
    chk("t2_done_cyc", done_cyc, s + 3); chk("t2_done_with_strobe", done_cyc, st_cyc[0]);
    // trigger wait
    start_run(2, 2, 1, s);
    repeat (10) @(negedge clk); #1;
    chk("t3_arm_en", n_en, 0); chk("t3_arm_strobes", n_st, 0); chk("t3_arm_busy", bus.busy, 1);
    t = cyc; bus.trig = 1'b1;
    @(negedge clk); #1; bus.trig = 1'b0;
    wait_idle(100);
    chk("t3_first_en", first_en, t + 1); chk("t3_done_n", n_done, 1);
    chk("t3_count", bus.sample_count, 2);
    // continuous run aborted on the tick that would issue strobe 8
    start_run(1, 0, 0, s);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); #1;
      if (n_st == 7 && bus.tick) break;
    end
    tk = bus.tick; a = cyc + 1; bus.abort = 1'b1;
    @(negedge clk); #1; bus.abort = 1'b0;
    repeat (3) @(negedge clk); #1;
    chk("t4_abort_on_tick", tk, 1); chk("t4_count", bus.sample_count, 7);
    chk("t4_strobes", n_st, 7); chk("t4_done_n", n_done, 0);
    chk("t4_idle_cyc", idle_cyc, a); chk("t4_last_en", last_en, a - 1);
    // ignored restart, then async reset mid-run
    start_run(3, 20, 0, s);
    for (int k = 0; k < 100 && n_st < 1; k++) begin @(negedge clk); #1; end
    bus.divisor = 8'd9; bus.sample_limit = W'(1); bus.start = 1'b1;
    @(negedge clk); #1; bus.start = 1'b0;
    repeat (6) @(negedge clk); #1;
    chk("t5_div_kept", bus.div_divisor, 3); chk("t5_still_run", bus.div_enable, 1);
    @(posedge clk); #2; rst_n = 1'b0; #1;
    chk("ar_busy", bus.busy, 0); chk("ar_en", bus.div_enable, 0);
    chk("ar_count", bus.sample_count, 0); chk("ar_div", bus.div_divisor, 0);
    chk("ar_done", bus.done, 0); chk("ar_strobe", bus.sample_strobe, 0);
    @(negedge clk); #1; rst_n = 1'b1;
    start_run(0, 2, 0, s);
    wait_idle(50);
    chk("t6_count", bus.sample_count, 2);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/capture_sequencer.md
# capture_sequencer

Sequences one sample-rate-divided capture run for the logic analyzer front end. Accepts a start command, latches the divisor and sample limit, and optionally waits for an external trigger. It then enables the external `clock_divider` and counts its ticks into sample strobes for the capture datapath. A run ends when the sample limit is reached or an abort arrives.

## Interface
- `CNT_W`, 16: width of sample limit and sample counter.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle start command, honoured only in IDLE.
- `abort` in 1: single-cycle abort, honoured in any non-IDLE state.
- `divisor` in 8: sample-rate divisor; latched on accepted `start`.
- `sample_limit` in CNT_W: samples per run; 0 means continuous; latched on accepted `start`.
- `trig_en` in 1: wait for trigger before running; latched on accepted `start`.
- `trig` in 1: trigger level, sampled only in ARM.
- `tick` in 1: tick from the divider.
- `div_enable` out 1: enable to the divider.
- `div_divisor` out 8: latched divisor to the divider.
- `sample_strobe` out 1: one-cycle sample enable to the capture datapath.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse on normal completion.
- `sample_count` out CNT_W: strobes issued in the current or last run.

## Operation
- States:
  - IDLE: `div_enable`=0. An accepted `start` latches the configuration, clears `sample_count`, and moves to ARM.
  - ARM: if latched `trig_en`=0, go to RUN next cycle. Otherwise stay until `trig`=1, then go to RUN.
  - RUN: `div_enable`=1. Each cycle with `tick`=1 produces `sample_strobe`=1 in the following cycle and increments `sample_count`.
    - Limited mode: when the tick that issues strobe number `sample_limit` is seen, go to DONE.
    - Continuous mode: stays in RUN until `abort`.
  - DONE: `done`=1 for exactly one cycle, `div_enable`=0, then IDLE.
- `abort` in ARM, RUN or DONE forces IDLE next cycle. No `done` pulse is issued.
- `abort` takes priority over a same-cycle `tick`: no strobe is issued and the count is unchanged.
- `start` while `busy`=1 is ignored. The latched configuration is unchanged.
- `tick` outside RUN is ignored.
- `div_divisor` holds its latched value until the next accepted `start`, including through IDLE.
- `sample_count` saturates at all-ones in continuous mode. It holds its value in IDLE after a run.
- Limit comparison is done with a down-counter of remaining samples, loaded from `sample_limit`. It is not done by comparing `sample_count` to the limit.

## Timing
- Reset values: state IDLE, `div_enable`=0, `div_divisor`=0, `sample_strobe`=0, `busy`=0, `done`=0, `sample_count`=0, remaining=0.
- `start` sampled at edge N: ARM and `busy`=1 from N+1. Without a trigger, RUN and `div_enable`=1 from N+2.
- With a trigger, `trig`=1 sampled at edge T in ARM gives RUN from T+1.
- The divider asserts its first tick `divisor`+1 cycles after `div_enable` rises, then every `divisor`+1 cycles.
- `tick` sampled at edge K in RUN gives `sample_strobe` high during cycle K+1 (one-cycle latency). `sample_count` updates at K+1.
- Last strobe and `done` coincide in the same cycle. IDLE and `busy`=0 follow one cycle later.
- Abort at edge A: `div_enable`=0 and `busy`=0 from A+1. A strobe registered at edge A from a tick at A−1 still appears.
- All outputs are registered or decoded directly from the state register; there are no combinational paths from inputs to outputs.

## Structure
- Shared package holds:
  - the state encoding (IDLE, ARM, RUN, DONE, 2 bits);
  - the `CNT_W` default;
  - a `SAMPLE_LIMIT_CONTINUOUS`=0 constant.
- One sub-module is natural: `sample_counter`, a loadable down-counter with zero flag plus a saturating up-counter.
- The divider stays external. Its synchronous active-high reset is driven by the top level, not by this block.

## Test plan
- `divisor`=3, `sample_limit`=4, `trig_en`=0, real `clock_divider` attached, start at cycle 0. Required: `busy` from 1, `div_enable` from 2, strobes spaced 4 cycles apart, 4 strobes, `done` with the 4th strobe, `sample_count`=4, IDLE next cycle.
- `divisor`=0, `sample_limit`=1. Required: exactly one strobe, coinciding with `done`; `div_enable` high for 2 cycles.
- `trig_en`=1 with `trig` held low for 10 cycles. Required: stays in ARM with `div_enable`=0 and no strobes; `trig`=1 gives RUN next cycle.
- `sample_limit`=0, `divisor`=1, abort after 7 strobes. Required: no `done` pulse; `sample_count`=7; `div_enable`=0 the cycle after abort; tick coincident with abort gives no strobe.
- Second `start` with `divisor`=9 mid-run. Required: ignored, `div_divisor` stays 3. Async `rst_n` low mid-RUN: all outputs at reset values immediately, without a clock edge.
